// File: rtl/serial_subtract.sv
// serial_subtract
//   Digit-serial subtractor: D = A - B - BIN over WIDTH bits, DIGIT bits per
//   clock, least-significant digit first. A start/busy/done handshake frames
//   each operation. The result is held until the next completion.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits per cycle (1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request; sampled only while busy == 0
//   a      in   minuend, captured on the accepted start edge
//   b      in   subtrahend, captured on the accepted start edge
//   bin    in   borrow-in, captured on the accepted start edge
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when d/bout are updated
//   d      out  difference (registered)
//   bout   out  final borrow-out (registered)
//
// Build option
//   SERIAL_SUBTRACT_SAT_EN  when defined, a completion with final borrow 1
//                           writes d = 0 (unsigned floor); bout still reports 1.
module serial_subtract #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    count;

    logic [DIGIT:0]   diff;
    logic [WIDTH-1:0] dig_ext;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACT_SAT_EN
    // Unsigned floor: a negative result (final borrow set) clamps to zero.
    function automatic logic [WIDTH-1:0] sat_floor(input logic [WIDTH-1:0] v,
                                                   input logic             brw);
        return brw ? '0 : v;
    endfunction
`endif

    // One digit of the subtract; bit DIGIT of the extended result is the borrow.
    always_comb begin
        diff     = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, borrow};
        dig_ext  = WIDTH'(diff[DIGIT-1:0]);
        // New digit enters at the MSB end so that after N digits the LSB
        // digit has reached bit 0.
        res_next = (res_sh >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        res_sh <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    borrow <= diff[DIGIT];
                    res_sh <= res_next;
                    if (count == CW'(N - 1)) begin
`ifdef SERIAL_SUBTRACT_SAT_EN
                        d <= sat_floor(res_next, diff[DIGIT]);
`else
                        d <= res_next;
`endif
                        bout  <= diff[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtract.sv
module tb_serial_subtract;

    localparam int N0 = 4;  // 16 / 4

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start0 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0;
    logic        bin0 = 1'b0;
    logic        busy0, done0, bout0;
    logic [15:0] d0;

    logic        start1 = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic        bin1 = 1'b0;
    logic        busy1, done1, bout1;
    logic [0:0]  d1;

    int cmps = 0;
    int errs = 0;

    always #1 clk = ~clk;

    serial_subtract #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .bin(bin0),
        .busy(busy0), .done(done0), .d(d0), .bout(bout0)
    );

    serial_subtract #(.WIDTH(1), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected d for a result whose hand-computed wrapped value is wd.
    function automatic logic [15:0] exp_d(input logic [15:0] wd, input logic brw);
`ifdef SERIAL_SUBTRACT_SAT_EN
        return brw ? 16'h0000 : wd;
`else
        return wd;
`endif
    endfunction

    // Called at a negedge: presents a request for one edge, returns at the
    // negedge right after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bi);
        start0 = 1'b1; a0 = a; b0 = b; bin0 = bi;
        @(negedge clk);
        start0 = 1'b0; a0 = '0; b0 = '0; bin0 = 1'b0;
    endtask

    // Waits (bounded) for done; cycle count is relative to the negedge after
    // the accepting edge, so done must appear at exactly N0.
    task automatic wait_done(input int init, input logic [15:0] ed, input logic eb,
                             input string tag);
        int cyc;
        cyc = init;
        while (done0 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, N0);
        chk({tag, "_d"}, d0, ed);
        chk({tag, "_bout"}, bout0, eb);
    endtask

    initial begin
        logic [7:0] d_tab;
        logic [7:0] b_tab;
        logic [15:0] held;
        int          dseen;
        int          cyc1;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_d", d0, 16'h0000);
        chk("rst_bout", bout0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 1234 - 0234 = 1000
        launch(16'h1234, 16'h0234, 1'b0);
        chk("t1_busy", busy0, 1'b1);
        chk("t1_d_hold", d0, 16'h0000);
        wait_done(0, 16'h1000, 1'b0, "t1");
        @(negedge clk);
        chk("t1_done_pulse", done0, 1'b0);
        chk("t1_d_stable", d0, 16'h1000);

        // 2: 0000 - 0001 wraps to FFFF with borrow
        launch(16'h0000, 16'h0001, 1'b0);
        wait_done(0, exp_d(16'hFFFF, 1'b1), 1'b1, "t2");
        @(negedge clk);

        // 3: 5555 - 5555 - 1 = FFFF, then back-to-back FFFF - 0 - 1 = FFFE
        launch(16'h5555, 16'h5555, 1'b1);
        wait_done(0, exp_d(16'hFFFF, 1'b1), 1'b1, "t3a");
        launch(16'hFFFF, 16'h0000, 1'b1);
        chk("t3_b2b_busy", busy0, 1'b1);
        wait_done(0, 16'hFFFE, 1'b0, "t3b");
        @(negedge clk);

        // 5: start during RUN is ignored
        launch(16'h8000, 16'h0001, 1'b0);
        start0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; bin0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; a0 = 16'hABCD; b0 = 16'h0F0F; bin0 = 1'b1;
        chk("t5_busy_mid", busy0, 1'b1);
        chk("t5_d_hold", d0, 16'hFFFE);
        wait_done(1, 16'h7FFF, 1'b0, "t5");
        a0 = '0; b0 = '0; bin0 = 1'b0;
        @(negedge clk);
        chk("t5_idle", busy0, 1'b0);

        // 6: reset in RUN cycle 2 aborts with no done pulse
        launch(16'h1234, 16'h0234, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy0, 1'b0);
        chk("t6_done", done0, 1'b0);
        chk("t6_d", d0, 16'h0000);
        chk("t6_bout", bout0, 1'b0);
        dseen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0 === 1'b1) dseen++;
        end
        chk("t6_no_done", dseen, 0);

        // 4: WIDTH=1 DIGIT=1 full-subtractor truth table, index {a,b,bin}
        d_tab = 8'h96;
        b_tab = 8'h8E;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            start1 = 1'b1; a1 = vv[2]; b1 = vv[1]; bin1 = vv[0];
            @(negedge clk);
            start1 = 1'b0;
            cyc1 = 0;
            while (done1 !== 1'b1 && cyc1 < 10) begin
                @(negedge clk);
                cyc1++;
            end
            chk($sformatf("t4_lat_%0d", v), cyc1, 1);
            chk($sformatf("t4_d_%0d", v), d1, exp_d({15'd0, d_tab[v]}, b_tab[v]));
            chk($sformatf("t4_bout_%0d", v), bout1, b_tab[v]);
            @(negedge clk);
        end

        held = d0;
        chk("final_d0_quiet", held, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
